// File: rtl/unsigned_mul_ha_pkg.sv
// Shared constants and the row-value helper for the approximate 8x8 multiplier's
// half-adder array reduction.
package unsigned_mul_ha_pkg;

  localparam int HA_ARRAYS = 4;
  localparam int HA_B_W    = 7;
  localparam int HA_T_W    = 9;
  localparam int ROW_V_W   = 10;
  // Width of a row-pair partial sum: 1019 + 4*1019 = 5095 fits in 13 bits.
  localparam int PAIR_W    = 13;

  function automatic logic [ROW_V_W-1:0] row_value(input logic [HA_B_W-1:0] b,
                                                   input logic [HA_T_W-1:0] t);
    return ROW_V_W'(t) + (ROW_V_W'(b) << 2);
  endfunction

endpackage

// File: rtl/unsigned_mul_ha_row_value.sv
// Combinational value of one half-adder row pair: sum row plus carry row
// shifted two places.
import unsigned_mul_ha_pkg::*;

module unsigned_mul_ha_row_value (
  input  logic [HA_B_W-1:0]  b_i,
  input  logic [HA_T_W-1:0]  t_i,
  output logic [ROW_V_W-1:0] v_o
);

  assign v_o = row_value(b_i, t_i);

endmodule

// File: rtl/unsigned_mul_8x8_ha_array_reduce.sv
// Final reduction of the four half-adder row-pair arrays into a saturated product,
// two-stage valid/ready pipeline. Optional saturation counter: UNSIGNED_MUL_HA_SAT_CNT_EN.
import unsigned_mul_ha_pkg::*;

module unsigned_mul_8x8_ha_array_reduce #(
  parameter int OUT_W = 16
`ifdef UNSIGNED_MUL_HA_SAT_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HA_B_W-1:0] ha_array_0_b,
  input  logic [HA_T_W-1:0] ha_array_0_t,
  input  logic [HA_B_W-1:0] ha_array_1_b,
  input  logic [HA_T_W-1:0] ha_array_1_t,
  input  logic [HA_B_W-1:0] ha_array_2_b,
  input  logic [HA_T_W-1:0] ha_array_2_t,
  input  logic [HA_B_W-1:0] ha_array_3_b,
  input  logic [HA_T_W-1:0] ha_array_3_t,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  product,
  output logic              sat
`ifdef UNSIGNED_MUL_HA_SAT_CNT_EN
  , output logic [CNT_W-1:0] sat_count
`endif
);

  logic [HA_B_W-1:0]  b_arr [HA_ARRAYS];
  logic [HA_T_W-1:0]  t_arr [HA_ARRAYS];
  logic [ROW_V_W-1:0] v     [HA_ARRAYS];

  assign b_arr[0] = ha_array_0_b;
  assign b_arr[1] = ha_array_1_b;
  assign b_arr[2] = ha_array_2_b;
  assign b_arr[3] = ha_array_3_b;
  assign t_arr[0] = ha_array_0_t;
  assign t_arr[1] = ha_array_1_t;
  assign t_arr[2] = ha_array_2_t;
  assign t_arr[3] = ha_array_3_t;

  for (genvar k = 0; k < HA_ARRAYS; k++) begin : g_row
    unsigned_mul_ha_row_value u_row (
      .b_i (b_arr[k]),
      .t_i (t_arr[k]),
      .v_o (v[k])
    );
  end

  // Array k+1 sits two bit positions above array k.
  logic [PAIR_W-1:0] s01_d, s23_d, s01_q, s23_q;
  assign s01_d = PAIR_W'(v[0]) + (PAIR_W'(v[1]) << 2);
  assign s23_d = PAIR_W'(v[2]) + (PAIR_W'(v[3]) << 2);

  logic s1_valid_q, s2_valid_q;
  logic s1_en, s2_en;

  assign s2_en    = !s2_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (s1_en) begin
      s1_valid_q <= in_valid;
    end
  end

  // NOTE: pure datapath registers carry no reset; their contents are only
  // meaningful under the matching valid bit, which is reset.
  always_ff @(posedge clk) begin
    if (s1_en && in_valid) begin
      s01_q <= s01_d;
      s23_q <= s23_d;
    end
  end

  logic [OUT_W:0]   sum;
  logic [OUT_W-1:0] product_d, product_q;
  logic             sat_d, sat_q;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sum       = (OUT_W+1)'(s01_q) + ((OUT_W+1)'(s23_q) << 4);
    sat_d     = sum[OUT_W];
    product_d = sum[OUT_W-1:0];
    if (sat_d) begin
      product_d = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      product_q  <= '0;
      sat_q      <= 1'b0;
    end else if (s2_en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        product_q <= product_d;
        sat_q     <= sat_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign product   = product_q;
  assign sat       = sat_q;

`ifdef UNSIGNED_MUL_HA_SAT_CNT_EN
  logic [CNT_W-1:0] sat_count_q;

  // Counts delivered saturated products; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count_q <= '0;
    end else if (s2_valid_q && out_ready && sat_q && !(&sat_count_q)) begin
      sat_count_q <= sat_count_q + 1'b1;
    end
  end

  assign sat_count = sat_count_q;
`else
  // Counter disabled: no sat_count port and no counter state.
`endif

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_array_reduce.sv
// Self-checking bench: directed cases plus randomized traffic against an
// arithmetic reference model and an in-order scoreboard.
module tb_unsigned_mul_8x8_ha_array_reduce;

  typedef struct packed {
    logic [15:0] p;
    logic        s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        sat;
  logic [6:0]  b_v [4];
  logic [8:0]  t_v [4];
`ifdef UNSIGNED_MUL_HA_SAT_CNT_EN
  logic [15:0] sat_count;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb [$];
  exp_t none;
  logic accepted, delivered;
  logic prev_stall;
  logic [15:0] prev_p;
  logic prev_s;
  int   exp_cnt;

  always #5 clk = ~clk;

  unsigned_mul_8x8_ha_array_reduce dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ha_array_0_b (b_v[0]),
    .ha_array_0_t (t_v[0]),
    .ha_array_1_b (b_v[1]),
    .ha_array_1_t (t_v[1]),
    .ha_array_2_b (b_v[2]),
    .ha_array_2_t (t_v[2]),
    .ha_array_3_b (b_v[3]),
    .ha_array_3_t (t_v[3]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .sat          (sat)
`ifdef UNSIGNED_MUL_HA_SAT_CNT_EN
    , .sat_count  (sat_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: every sum-row bit of array k weighs 2^(2k+i), every carry-row bit 2^(2k+i+2).
  function automatic exp_t model(input logic [63:0] d);
    int unsigned total;
    exp_t e;
    total = 0;
    for (int k = 0; k < 4; k++) begin
      total += int'(d[16*k +: 9]) * (4 ** k) + int'(d[16*k+9 +: 7]) * (4 ** (k + 1));
    end
    e.s = (total > 65535);
    e.p = e.s ? 16'hFFFF : total[15:0];
    return e;
  endfunction

  // One clock: drive at the falling edge, observe 1 time unit later, account for
  // the transfers that the next rising edge will perform.
  task automatic cycle(input logic iv, input logic ordy, input logic [63:0] d,
                       input logic use_lit, input exp_t lit);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    for (int k = 0; k < 4; k++) begin
      t_v[k] = d[16*k +: 9];
      b_v[k] = d[16*k+9 +: 7];
    end
    #1;
    if (prev_stall) begin
      check("hold_valid", 32'(out_valid), 1);
      check("hold_product", 32'(product), 32'(prev_p));
      check("hold_sat", 32'(sat), 32'(prev_s));
    end
`ifdef UNSIGNED_MUL_HA_SAT_CNT_EN
    check("sat_count", 32'(sat_count), 32'(exp_cnt));
`endif
    delivered = out_valid && out_ready;
    if (delivered) begin
      check("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("product", 32'(product), 32'(e.p));
        check("sat", 32'(sat), 32'(e.s));
        if (e.s && exp_cnt != 65535) exp_cnt++;
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) sb.push_back(use_lit ? lit : model(d));
    prev_stall = out_valid && !out_ready;
    prev_p     = product;
    prev_s     = sat;
  endtask

  task automatic send(input logic [63:0] d, input logic use_lit, input exp_t lit);
    int n = 0;
    do begin
      cycle(1'b1, 1'b1, d, use_lit, lit);
      n++;
    end while (!accepted && n < 20);
    check("send_accepted", 32'(accepted), 1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      cycle(1'b0, 1'b1, 64'h0, 1'b0, none);
      n++;
    end
    check("drain_empty", 32'(sb.size()), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    prev_stall = 1'b0;
    exp_cnt    = 0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_product", 32'(product), 0);
    check("rst_sat", 32'(sat), 0);
`ifdef UNSIGNED_MUL_HA_SAT_CNT_EN
    check("rst_sat_count", 32'(sat_count), 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int outs;
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    none       = '0;
    prev_stall = 1'b0;
    exp_cnt    = 0;
    for (int k = 0; k < 4; k++) begin
      b_v[k] = '0;
      t_v[k] = '0;
    end
    do_reset();

    // All-zero input: product 0 exactly two cycles after acceptance.
    cycle(1'b1, 1'b1, 64'h0, 1'b1, '{p: 16'd0, s: 1'b0});
    check("t1_accept", 32'(accepted), 1);
    cycle(1'b0, 1'b1, 64'h0, 1'b0, none);
    check("t1_lat1_valid", 32'(out_valid), 0);
    cycle(1'b0, 1'b1, 64'h0, 1'b0, none);
    check("t1_lat2_valid", 32'(out_valid), 1);
    drain();

    // Lowest sum bit of each array.
    send(64'h0001_0001_0001_0001, 1'b1, '{p: 16'd85, s: 1'b0});
    drain();
    // Array 3 fully set: largest non-saturating single-array value.
    send(64'hFFFF_0000_0000_0000, 1'b1, '{p: 16'd65216, s: 1'b0});
    drain();
    // Everything set: 86615 clamps to all-ones.
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, '{p: 16'hFFFF, s: 1'b1});
    drain();
`ifdef UNSIGNED_MUL_HA_SAT_CNT_EN
    cycle(1'b0, 1'b1, 64'h0, 1'b0, none);
    check("t4_sat_count", 32'(sat_count), 1);
`endif

    // Backpressure: only two items fit while the output is blocked.
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      cycle(idx < 3, 1'b0, 64'(idx + 1), 1'b1, '{p: 16'(idx + 1), s: 1'b0});
      if (accepted) idx++;
    end
    check("t5_accepts", 32'(idx), 2);
    check("t5_in_ready_low", 32'(in_ready), 0);
    outs = 0;
    for (int c = 0; c < 3; c++) begin
      cycle(idx < 3, 1'b1, 64'(idx + 1), 1'b1, '{p: 16'(idx + 1), s: 1'b0});
      if (accepted) idx++;
      if (delivered) outs++;
    end
    check("t5_no_gaps", 32'(outs), 3);
    check("t5_all_sent", 32'(idx), 3);
    drain();

    // Reset with both stages full discards the contents.
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1, 1'b0, {$urandom, $urandom}, 1'b0, none);
    end
    check("t6_full_in_ready", 32'(in_ready), 0);
    check("t6_full_out_valid", 32'(out_valid), 1);
    do_reset();

    // Randomized traffic with random stalls on both sides.
    for (int c = 0; c < 400; c++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            {$urandom, $urandom}, 1'b0, none);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
